// File: rtl/ram_stream_reader.sv
// ram_stream_reader
// Burst read client for a dual-port RAM with a 1-cycle registered read.
// A (base, length) request is turned into consecutive read addresses;
// returning words pass through a 3-entry skid FIFO to a valid/ready stream.
module ram_stream_reader #(
   parameter int addr_width = 4,
   parameter int mem_width  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [addr_width-1:0] base_addr,
   input  logic [addr_width:0]   length,
   output logic                  busy,
   output logic                  done,
   output logic [addr_width-1:0] ram_read_address,
   input  logic [mem_width-1:0]  ram_read_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [mem_width-1:0]  out_data,
   output logic                  out_last
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam logic [addr_width-1:0] ADDR_ONE = 1;
   localparam logic [addr_width:0]   LEN_ONE  = 1;

   state_t                r_state;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_issue;       // stage A: address presented to RAM this cycle
   logic                  r_rd_vld;      // stage B: RAM read data valid this cycle
   logic [addr_width-1:0] r_addr;        // next address to issue
   logic [addr_width-1:0] r_raddr;
   logic [addr_width:0]   r_issue_left;
   logic [addr_width:0]   r_pop_left;
   logic [1:0]            r_cnt;
   logic [mem_width-1:0]  r_mem [3];     // entry 0 is the head

   logic                  w_pop;
   logic                  w_push;
   logic                  w_can_issue;
   logic [2:0]            w_occ;
   logic [2:0]            w_occ_after;
   logic [1:0]            w_wr_idx;

   // Everything in flight (issued, returning, buffered) must fit the FIFO
   // once it lands, so issue only while post-pop occupancy leaves a slot.
   assign w_pop       = (r_cnt != 2'd0) && out_ready;
   assign w_push      = r_rd_vld;
   assign w_occ       = {2'b00, r_issue} + {2'b00, r_rd_vld} + {1'b0, r_cnt};
   assign w_occ_after = w_occ - {2'b00, w_pop};
   assign w_can_issue = (r_state == S_RUN) && (r_issue_left != '0) && (w_occ_after < 3'd3);
   assign w_wr_idx    = r_cnt - {1'b0, w_pop};

   // FIFO storage: shift toward the head on pop, arriving word lands behind the survivors
   always_ff @(posedge clk) begin
      if (w_pop) begin
         r_mem[0] <= r_mem[1];
         r_mem[1] <= r_mem[2];
      end
      if (w_push) begin
         r_mem[w_wr_idx] <= ram_read_data;
      end
   end

   // Burst FSM, address issue, read pipeline valids and FIFO occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_issue      <= 1'b0;
         r_rd_vld     <= 1'b0;
         r_addr       <= '0;
         r_raddr      <= '0;
         r_issue_left <= '0;
         r_pop_left   <= '0;
         r_cnt        <= '0;
      end else begin
         r_rd_vld <= r_issue;
         r_issue  <= 1'b0;
         r_cnt    <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
         if (w_pop) begin
            r_pop_left <= r_pop_left - LEN_ONE;
         end
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_busy     <= 1'b1;
                  r_pop_left <= length;
                  if (length == '0) begin
                     r_issue_left <= '0;
                     r_state      <= S_DONE;
                  end else begin
                     // First address goes out straight from the request
                     r_issue      <= 1'b1;
                     r_raddr      <= base_addr;
                     r_addr       <= base_addr + ADDR_ONE;
                     r_issue_left <= length - LEN_ONE;
                     r_state      <= (length == LEN_ONE) ? S_DRAIN : S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (w_can_issue) begin
                  r_issue      <= 1'b1;
                  r_raddr      <= r_addr;
                  r_addr       <= r_addr + ADDR_ONE;
                  r_issue_left <= r_issue_left - LEN_ONE;
                  if (r_issue_left == LEN_ONE) begin
                     r_state <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (w_pop && (r_pop_left == LEN_ONE)) begin
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               // An empty burst enters with done low and spends one extra cycle here
               if (!r_done) begin
                  r_done <= 1'b1;
               end else begin
                  r_done  <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy             = r_busy;
   assign done             = r_done;
   assign ram_read_address = r_raddr;
   assign out_valid        = (r_cnt != 2'd0);
   assign out_data         = out_valid ? r_mem[0] : '0;
   assign out_last         = out_valid && (r_pop_left == LEN_ONE);

endmodule

// File: tb/tb_ram_stream_reader.sv
// Testbench for ram_stream_reader: table of bursts with a RAM model
// preloaded as mem[i] = i + 100, plus hand-written reset sequences.
module tb_ram_stream_reader;

   localparam int AW = 4;
   localparam int MW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   length;
   logic          busy;
   logic          done;
   logic [AW-1:0] ram_read_address;
   logic [MW-1:0] ram_read_data;
   logic          out_valid;
   logic          out_ready;
   logic [MW-1:0] out_data;
   logic          out_last;

   logic [MW-1:0] mem [16];

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      int base;
      int len;
      int mode;      // 0: ready high, 1: ready on odd cycles, 2: ready low until cycle 10
      int intr;      // 1: extra start with another request at cycle 2
      int exp_fv;    // first cycle with out_valid, -1 if never
      int exp_nb;    // beats
      int exp_busy;  // cycles with busy high
      int exp_done;  // cycle of the done pulse
      int exp_addr;  // ram_read_address after the burst
   } rec_t;

   rec_t tbl [8];

   always #5 clk = ~clk;

   always @(posedge clk) ram_read_data <= mem[ram_read_address];

   ram_stream_reader #(.addr_width(AW), .mem_width(MW)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start            (start),
      .base_addr        (base_addr),
      .length           (length),
      .busy             (busy),
      .done             (done),
      .ram_read_address (ram_read_address),
      .ram_read_data    (ram_read_data),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_data         (out_data),
      .out_last         (out_last)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string nm);
      chk({nm, " busy"}, busy, 0);
      chk({nm, " done"}, done, 0);
      chk({nm, " out_valid"}, out_valid, 0);
      chk({nm, " out_last"}, out_last, 0);
      chk({nm, " out_data"}, out_data, 0);
      chk({nm, " ram_read_address"}, ram_read_address, 0);
   endtask

   task automatic run_burst(input int idx, input rec_t r);
      int cyc, k, fv, bc, dc, ndone, last_cyc;
      logic          prev_stall;
      logic [MW-1:0] prev_data;
      logic          prev_last;
      string         p;
      p = $sformatf("v%0d", idx);
      k = 0; fv = -1; bc = 0; dc = -1; ndone = 0; last_cyc = -1;
      prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
      @(posedge clk); #1;
      start     = 1'b1;
      base_addr = r.base[AW-1:0];
      length    = r.len[AW:0];
      out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc   = 1;
      while (1) begin
         if (cyc > 1 && !busy) break;
         if (cyc > 100) begin
            chk({p, " timeout"}, 1, 0);
            break;
         end
         if (busy) bc++;
         if (done) begin
            ndone++;
            if (dc < 0) dc = cyc;
         end
         if (r.intr != 0) begin
            if (cyc == 2) begin
               start = 1'b1; base_addr = 4'd9; length = 5'd3;
            end else begin
               start = 1'b0;
            end
         end
         case (r.mode)
            1:       out_ready = cyc[0];
            2:       out_ready = (cyc > 10);
            default: out_ready = 1'b1;
         endcase
         if (r.mode == 2 && cyc == 10)
            chk({p, " stall address"}, ram_read_address, (r.base + 2) % 16);
         if (prev_stall) begin
            chk({p, " stalled data stable"}, out_data, prev_data);
            chk({p, " stalled last stable"}, out_last, prev_last);
            chk({p, " stalled valid held"}, out_valid, 1);
         end
         if (out_valid) begin
            if (fv < 0) fv = cyc;
            chk($sformatf("%s data beat %0d", p, k), out_data, ((r.base + k) % 16) + 100);
            chk($sformatf("%s last beat %0d", p, k), out_last, (k == r.len - 1) ? 1 : 0);
            if (out_ready) begin
               k++;
               last_cyc = cyc;
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
         @(posedge clk); #1;
         cyc++;
      end
      start     = 1'b0;
      out_ready = 1'b1;
      chk({p, " first valid cycle"}, fv, r.exp_fv);
      chk({p, " beats"}, k, r.exp_nb);
      chk({p, " busy cycles"}, bc, r.exp_busy);
      chk({p, " done pulses"}, ndone, 1);
      chk({p, " done cycle"}, dc, r.exp_done);
      chk({p, " final address"}, ram_read_address, r.exp_addr);
      if (r.len > 0) chk({p, " done after last beat"}, dc, last_cyc + 1);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = MW'(i + 100);

      //         base len mode intr fv  nb busy done addr
      tbl[0] = '{ 0,   4,  0,   0,   3,  4,  7,   7,   3};
      tbl[1] = '{14,   4,  0,   0,   3,  4,  7,   7,   1};
      tbl[2] = '{ 3,   8,  1,   0,   3,  8, 18,  18,  10};
      tbl[3] = '{ 5,   1,  0,   0,   3,  1,  4,   4,   5};
      tbl[4] = '{ 0,  16,  0,   0,   3, 16, 19,  19,  15};
      tbl[5] = '{ 7,   0,  0,   0,  -1,  0,  2,   2,  15};
      tbl[6] = '{ 0,  16,  2,   0,   3, 16, 27,  27,  15};
      tbl[7] = '{ 2,   5,  0,   1,   3,  5,  8,   8,   6};

      rst_n     = 1'b0;
      start     = 1'b0;
      base_addr = '0;
      length    = '0;
      out_ready = 1'b0;
      #1;
      chk_idle_outputs("reset");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) run_burst(i, tbl[i]);

      // Reset in the middle of a burst after two beats
      @(posedge clk); #1;
      start = 1'b1; base_addr = 4'd4; length = 5'd8; out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      chk("abort beat0 data", out_data, 104);
      @(posedge clk); #1;
      chk("abort beat1 data", out_data, 105);
      @(posedge clk); #1;
      chk("abort busy before reset", busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_idle_outputs("async reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk($sformatf("post-reset done c%0d", i), done, 0);
         chk($sformatf("post-reset valid c%0d", i), out_valid, 0);
      end
      run_burst(8, '{9, 3, 0, 0, 3, 3, 6, 6, 11});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
